// File: rtl/sigmoid_sched_pkg.sv
// -----------------------------------------------------------------------------
// sigmoid_sched_pkg
// Shared definitions for the sigmoid request scheduler:
//   - sched_state_e : scheduler FSM states
//   - DEF_*         : default values for the scheduler parameters
// No ports (package).
// -----------------------------------------------------------------------------
package sigmoid_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESPOND   = 2'd3
    } sched_state_e;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/sigmoid_rr_pick.sv
// -----------------------------------------------------------------------------
// sigmoid_rr_pick
// Combinational round-robin picker. The search starts at last_grant+1
// (mod NUM_REQ) and returns the first requester found asserted.
// Ports:
//   req        in   NUM_REQ  request vector
//   last_grant in   IDX_W    index of the previously served requester
//   grant      out  NUM_REQ  one-hot winner (all zero when no request)
//   grant_idx  out  IDX_W    binary index of the winner
//   any        out  1        at least one request present
// -----------------------------------------------------------------------------
module sigmoid_rr_pick
    import sigmoid_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    logic        found_s;
    logic [31:0] sum_s;
    logic [IDX_W-1:0] cand_s;

    // Rotating priority search starting just after the previous winner.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        sum_s     = 32'd0;
        cand_s    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum_s  = 32'(last_grant) + 32'(i);
            cand_s = IDX_W'(sum_s % 32'(NUM_REQ));
            if (!found_s && req[cand_s]) begin
                found_s        = 1'b1;
                grant[cand_s]  = 1'b1;
                grant_idx      = cand_s;
            end else begin
                // earlier candidate already won, or this one is idle
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/sigmoid_req_scheduler.sv
// -----------------------------------------------------------------------------
// sigmoid_req_scheduler
// Shares one sigmoid_top core (ap_ctrl_hs, ap_continue tied high inside the
// core) between NUM_REQ requesters. One transaction is in flight at a time;
// requesters are served round-robin, requester 0 first after reset.
//
// Optional feature: define SIGMOID_SCHED_TIMEOUT_EN to enable a watchdog that
// aborts a core call after TIMEOUT_CYC cycles in START/WAIT_DONE, returns
// all-ones data and sets the sticky timeout_err flag. Without the macro the
// scheduler waits indefinitely for core_ap_done and timeout_err is 0.
//
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   req_valid/data    per-requester operand (requester i at [i*DATA_W +: DATA_W])
//   req_ready         one-hot accept strobe (combinational, IDLE only)
//   rsp_valid/data    one-hot result valid, shared result bus
//   rsp_ready         per-requester result accept (only the owner's is used)
//   core_*            handshake to the sigmoid core
//   busy              state is not IDLE
//   txn_count         completed transactions (wraps)
//   timeout_err       sticky watchdog flag
// -----------------------------------------------------------------------------
module sigmoid_req_scheduler
    import sigmoid_sched_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic                      core_ap_start,
    input  logic                      core_ap_ready,
    input  logic                      core_ap_done,
    output logic [DATA_W-1:0]         core_x,
    input  logic [DATA_W-1:0]         core_ap_return,
    output logic                      busy,
    output logic [31:0]               txn_count,
    output logic                      timeout_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_e      state_q,      state_d;
    logic [DATA_W-1:0] operand_q,    operand_d;
    logic [IDX_W-1:0]  owner_q,      owner_d;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic [DATA_W-1:0] rsp_data_q,   rsp_data_d;
    logic [31:0]       txn_count_q,  txn_count_d;

    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               any_req_s;
    logic               timeout_hit_s;
    logic [NUM_REQ-1:0] owner_oh_s;

    sigmoid_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s),
        .any        (any_req_s)
    );

`ifdef SIGMOID_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic             timeout_fire_s;

    // Watchdog count; restarts from 0 on every entry to START.
    always_comb begin
        if ((state_q == ST_START) || (state_q == ST_WAIT_DONE)) begin
            wd_cnt_d = timeout_hit_s ? wd_cnt_q : (wd_cnt_q + CNT_W'(1));
        end else begin
            wd_cnt_d = '0;
        end
    end

    // The 255th core cycle (cnt 254 for the default) is the last allowed one.
    assign timeout_hit_s = (wd_cnt_q >= CNT_W'(TIMEOUT_CYC - 1));

    // A timeout only fires when the core did not complete in the same cycle.
    assign timeout_fire_s = timeout_hit_s &&
                            (((state_q == ST_START) && !core_ap_ready) ||
                             ((state_q == ST_WAIT_DONE) && !core_ap_done));

    assign timeout_err_d = timeout_err_q | timeout_fire_s;

    // Watchdog counter and sticky error flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // Next-state and datapath update for the scheduler FSM.
    always_comb begin
        state_d      = state_q;
        operand_d    = operand_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        txn_count_d  = txn_count_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    operand_d = req_data[grant_idx_s*DATA_W +: DATA_W];
                    owner_d   = grant_idx_s;
                    state_d   = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (core_ap_ready) begin
                    if (core_ap_done) begin
                        rsp_data_d = core_ap_return;
                        state_d    = ST_RESPOND;
                    end else begin
                        state_d = ST_WAIT_DONE;
                    end
                end else if (timeout_hit_s) begin
                    rsp_data_d = '1;
                    state_d    = ST_RESPOND;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_WAIT_DONE: begin
                if (core_ap_done) begin
                    rsp_data_d = core_ap_return;
                    state_d    = ST_RESPOND;
                end else if (timeout_hit_s) begin
                    rsp_data_d = '1;
                    state_d    = ST_RESPOND;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_RESPOND: begin
                if (rsp_ready[owner_q]) begin
                    last_grant_d = owner_q;
                    txn_count_d  = txn_count_q + 32'd1;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESPOND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scheduler state registers; reset abandons any transaction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            operand_q    <= '0;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            rsp_data_q   <= '0;
            txn_count_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            operand_q    <= operand_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            txn_count_q  <= txn_count_d;
        end
    end

    assign owner_oh_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

    // Output decode from registered state; req_ready is suppressed during reset.
    always_comb begin
        if ((state_q == ST_IDLE) && !reset) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
        if (state_q == ST_RESPOND) begin
            rsp_valid = owner_oh_s;
        end else begin
            rsp_valid = '0;
        end
    end

    assign core_ap_start = (state_q == ST_START);
    assign core_x        = operand_q;
    assign rsp_data      = rsp_data_q;
    assign busy          = (state_q != ST_IDLE);
    assign txn_count     = txn_count_q;

endmodule

// File: tb/tb_sigmoid_req_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_req_scheduler
// Directed bench: a cycle table (inputs + expected outputs per cycle) followed
// by hand-written sequences for round-robin order, response back-pressure,
// reset during a core call and, when SIGMOID_SCHED_TIMEOUT_EN is defined, the
// watchdog. Inputs change on the falling edge, outputs are checked 1 time
// unit later.
// -----------------------------------------------------------------------------
module tb_sigmoid_req_scheduler;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_ready;
    logic        core_ap_start;
    logic        core_ap_ready;
    logic        core_ap_done;
    logic [15:0] core_x;
    logic [15:0] core_ap_return;
    logic        busy;
    logic [31:0] txn_count;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_data [4];

    typedef struct {
        logic [3:0]  rv;
        logic        ar;
        logic        ad;
        logic [15:0] ret;
        logic [3:0]  rr;
        logic [3:0]  e_rq;
        logic [3:0]  e_rs;
        logic        e_st;
        logic        e_busy;
        logic [15:0] e_rd;
        logic [15:0] e_cx;
        logic [31:0] e_txn;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    sigmoid_req_scheduler #(
        .NUM_REQ     (4),
        .DATA_W      (16),
        .TIMEOUT_CYC (255)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_ready      (rsp_ready),
        .core_ap_start  (core_ap_start),
        .core_ap_ready  (core_ap_ready),
        .core_ap_done   (core_ap_done),
        .core_x         (core_x),
        .core_ap_return (core_ap_return),
        .busy           (busy),
        .txn_count      (txn_count),
        .timeout_err    (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench time limit reached");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] rv, input logic ar, input logic ad,
                                input logic [15:0] ret, input logic [3:0] rr,
                                input logic [3:0] e_rq, input logic [3:0] e_rs,
                                input logic e_st, input logic e_busy,
                                input logic [15:0] e_rd, input logic [15:0] e_cx,
                                input logic [31:0] e_txn);
        vec_t v;
        v.rv = rv; v.ar = ar; v.ad = ad; v.ret = ret; v.rr = rr;
        v.e_rq = e_rq; v.e_rs = e_rs; v.e_st = e_st; v.e_busy = e_busy;
        v.e_rd = e_rd; v.e_cx = e_cx; v.e_txn = e_txn;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; req_valid = 4'b0000; rsp_ready = 4'b0000;
        core_ap_ready = 1'b0; core_ap_done = 1'b0; core_ap_return = 16'h0000;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One transaction with req_valid=1111 held; core answers in the start cycle.
    task automatic do_txn(input int idx, input logic [15:0] ret, input int hold);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        @(negedge clock);
        rsp_ready = 4'b0000; req_valid = 4'b1111;
        #1;
        chk($sformatf("rr_grant_%0d", idx), 32'(req_ready), 32'(oh));
        @(negedge clock);
        core_ap_ready = 1'b1; core_ap_done = 1'b1; core_ap_return = ret;
        #1;
        chk("rr_start", 32'(core_ap_start), 32'd1);
        chk("rr_core_x", 32'(core_x), 32'(exp_data[idx]));
        chk("rr_no_ready_in_start", 32'(req_ready), 32'd0);
        @(negedge clock);
        core_ap_ready = 1'b0; core_ap_done = 1'b0; core_ap_return = 16'hDEAD;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clock);
            rsp_ready = (h == hold) ? oh : ~oh;
            #1;
            chk("rr_rsp_valid", 32'(rsp_valid), 32'(oh));
            chk("rr_rsp_data", 32'(rsp_data), 32'(ret));
            chk("rr_no_ready_in_respond", 32'(req_ready), 32'd0);
        end
    endtask

    initial begin
        exp_data[0] = 16'h0000; exp_data[1] = 16'h1111;
        exp_data[2] = 16'h2222; exp_data[3] = 16'h3333;
        req_data = {exp_data[3], exp_data[2], exp_data[1], exp_data[0]};
        reset = 1'b1; req_valid = 4'b0000; rsp_ready = 4'b0000;
        core_ap_ready = 1'b0; core_ap_done = 1'b0; core_ap_return = 16'h0000;

        //            rv       ar    ad    ret       rr       e_rq     e_rs     st    busy  e_rd      e_cx      txn
        tbl[0]  = mk(4'b0001, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'd0);
        tbl[1]  = mk(4'b0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 32'd0);
        tbl[2]  = mk(4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 32'd0);
        tbl[3]  = mk(4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 32'd0);
        tbl[4]  = mk(4'b0000, 1'b0, 1'b1, 16'h0800, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 32'd0);
        tbl[5]  = mk(4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, 16'h0800, 16'h0000, 32'd0);
        tbl[6]  = mk(4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1, 16'h0800, 16'h0000, 32'd0);
        tbl[7]  = mk(4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0800, 16'h0000, 32'd1);
        tbl[8]  = mk(4'b0100, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0, 16'h0800, 16'h0000, 32'd1);
        tbl[9]  = mk(4'b1000, 1'b1, 1'b1, 16'h0ABC, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 16'h0800, 16'h2222, 32'd1);
        tbl[10] = mk(4'b1000, 1'b0, 1'b0, 16'h0000, 4'b1011, 4'b0000, 4'b0100, 1'b0, 1'b1, 16'h0ABC, 16'h2222, 32'd1);
        tbl[11] = mk(4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b1, 16'h0ABC, 16'h2222, 32'd1);
        tbl[12] = mk(4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0ABC, 16'h0000, 32'd2);
        tbl[13] = mk(4'b0011, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 16'h0ABC, 16'h0000, 32'd2);
        tbl[14] = mk(4'b0011, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 16'h0ABC, 16'h0000, 32'd2);
        tbl[15] = mk(4'b0011, 1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 16'h0ABC, 16'h0000, 32'd2);
        tbl[16] = mk(4'b0011, 1'b0, 1'b1, 16'h1234, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 16'h0ABC, 16'h0000, 32'd2);
        tbl[17] = mk(4'b0011, 1'b0, 1'b0, 16'h0000, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b1, 16'h1234, 16'h0000, 32'd2);
        tbl[18] = mk(4'b0011, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0, 16'h1234, 16'h0000, 32'd3);
        tbl[19] = mk(4'b0000, 1'b1, 1'b1, 16'h5555, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 16'h1234, 16'h1111, 32'd3);
        tbl[20] = mk(4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b1, 16'h5555, 16'h1111, 32'd3);
        tbl[21] = mk(4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h5555, 16'h0000, 32'd4);

        // Reset values, with a request present while reset is still high.
        repeat (2) @(posedge clock);
        @(negedge clock);
        req_valid = 4'b0001;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_start", 32'(core_ap_start), 32'd0);
        chk("rst_core_x", 32'(core_x), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_txn", txn_count, 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clock);
        reset = 1'b0; req_valid = 4'b0000;

        // Cycle table.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clock);
            req_valid = tbl[i].rv; core_ap_ready = tbl[i].ar; core_ap_done = tbl[i].ad;
            core_ap_return = tbl[i].ret; rsp_ready = tbl[i].rr;
            #1;
            chk($sformatf("row%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].e_rq));
            chk($sformatf("row%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rs));
            chk($sformatf("row%0d_start", i), 32'(core_ap_start), 32'(tbl[i].e_st));
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("row%0d_rsp_data", i), 32'(rsp_data), 32'(tbl[i].e_rd));
            chk($sformatf("row%0d_txn", i), txn_count, tbl[i].e_txn);
            if (tbl[i].e_busy) begin
                chk($sformatf("row%0d_core_x", i), 32'(core_x), 32'(tbl[i].e_cx));
            end
        end

        // Round-robin with all requesters valid; third one back-pressures 10 cycles.
        do_reset();
        do_txn(0, 16'h0100, 0);
        do_txn(1, 16'h0201, 0);
        do_txn(2, 16'h0302, 10);
        do_txn(3, 16'h0403, 0);
        do_txn(0, 16'h0504, 0);
        @(negedge clock);
        rsp_ready = 4'b0000; req_valid = 4'b0000;
        #1;
        chk("rr_txn_count", txn_count, 32'd5);
        chk("rr_idle", 32'(busy), 32'd0);

        // Reset while waiting for the core, then a late core_ap_done.
        @(negedge clock);
        req_valid = 4'b0001;
        #1;
        chk("rw_accept", 32'(req_ready), 32'b0001);
        @(negedge clock);
        req_valid = 4'b0000; core_ap_ready = 1'b1;
        @(negedge clock);
        core_ap_ready = 1'b0;
        #1;
        chk("rw_in_wait", 32'(busy), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; core_ap_done = 1'b1; core_ap_return = 16'h7777;
        #1;
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rw_rsp_data", 32'(rsp_data), 32'd0);
        chk("rw_txn", txn_count, 32'd0);
        chk("rw_start", 32'(core_ap_start), 32'd0);
        chk("rw_core_x", 32'(core_x), 32'd0);
        @(negedge clock);
        core_ap_done = 1'b0;
        #1;
        chk("rw_late_done_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rw_late_done_busy", 32'(busy), 32'd0);
        chk("rw_late_done_rsp_data", 32'(rsp_data), 32'd0);

`ifdef SIGMOID_SCHED_TIMEOUT_EN
        begin
            int  cyc;
            logic seen;
            cyc = 0; seen = 1'b0;
            @(negedge clock);
            req_valid = 4'b0001;
            @(negedge clock);
            req_valid = 4'b0000; core_ap_ready = 1'b1;
            for (int n = 0; n < 400 && !seen; n++) begin
                @(negedge clock);
                core_ap_ready = 1'b0;
                cyc++;
                #1;
                if (rsp_valid[0]) seen = 1'b1;
            end
            chk("to_seen", 32'(seen), 32'd1);
            chk("to_cycles", 32'(cyc), 32'd255);
            chk("to_err", 32'(timeout_err), 32'd1);
            chk("to_rsp_data", 32'(rsp_data), 32'hFFFF);
            rsp_ready = 4'b0001;
            @(negedge clock);
            rsp_ready = 4'b0000;
            #1;
            chk("to_err_sticky", 32'(timeout_err), 32'd1);
            chk("to_idle", 32'(busy), 32'd0);
            do_reset();
            #1;
            chk("to_err_cleared", 32'(timeout_err), 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
